store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Parametrised read-modify-write store engine that replaces the fixed 32-bit combinational store mask in the datapath. It accepts one store request at a time (address, size, data) and merges the sub-word lane into the current memory word. For partial-width stores it performs a memory read, merge and write-back under an FSM; for full-width stores it writes directly. It sits between the control unit / register B path and the data memory port.

## Interface

Parameters:
- DATA_W, 32, memory word width in bits; power of two, 32 or 64.
- ADDR_W, 32, byte-address width.
- OFF_W, log2(DATA_W/8) (derived localparam), byte-offset bits within a word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request; high exactly when the FSM is in IDLE.
- req_addr  input  ADDR_W  byte address of the store.
- req_size  input  2  store size:
  - 00: full DATA_W.
  - 01: half (16 bits).
  - 10: byte.
  - 11: word (32 bits) when DATA_W=64; treated as 00 when DATA_W=32.
- req_data  input  DATA_W  store data; the payload is right-justified (the LSBs).
- mem_addr  output  ADDR_W  word-aligned address (req_addr with the low OFF_W bits cleared).
- mem_rd  output  1  one-cycle read strobe.
- mem_rdata  input  DATA_W  read data, valid in the cycle after mem_rd.
- mem_wr  output  1  one-cycle write strobe.
- mem_wdata  output  DATA_W  merged write data.
- done  output  1  one-cycle pulse, coincident with mem_wr.
- err  output  1  one-cycle pulse on a misaligned request.

## Operation

- States: IDLE, READ, WAIT, WRITE, ERR.
- Request capture:
  - A request is accepted on the clock edge where req_valid && req_ready.
  - On acceptance, addr, size, data and offset are registered; inputs are ignored afterwards.
- Alignment check at acceptance:
  - half requires addr[0]=0.
  - 32-bit word (size 11, DATA_W=64) requires addr[1:0]=0.
  - byte and full are always aligned; for full, the offset bits are ignored.
  - A misaligned request goes IDLE->ERR. ERR asserts err, performs no memory access, does not assert done, then returns to IDLE.
- Transitions:
  - IDLE->WRITE for full-width stores.
  - IDLE->READ for partial stores.
  - READ (mem_rd=1) -> WAIT.
  - WAIT: capture mem_rdata -> WRITE.
  - WRITE (mem_wr=1, done=1) -> IDLE.
- Merge rules (little-endian lanes):
  - Byte at offset k occupies bits [8k+7:8k].
  - Half at offset k occupies bits [8k+15:8k].
  - Word at offset k occupies bits [8k+31:8k].
  - mem_wdata = captured read word with the selected lane replaced by the low bits of req_data. All other bits pass through unchanged.
  - For a full store, mem_wdata = req_data.
- mem_addr is held stable from READ through WRITE.
- All outputs except req_ready are registered, with no combinational path from the inputs.
- Reset:
  - Asynchronous and active-low: state returns to IDLE.
  - mem_rd, mem_wr, done and err go to 0. mem_addr and mem_wdata go to 0.
  - req_ready=1 whenever the FSM is in IDLE, including while reset is held.
  - Reset asserted mid-transaction abandons it: no mem_wr is issued and there is no done.

## Timing

- Request accepted at edge T:
  - Full store: mem_wr and done high in cycle T+1.
  - Partial store: mem_rd in T+1, mem_rdata sampled at end of T+2, mem_wr and done in T+3.
  - Misaligned: err in T+1.
- Back-to-back throughput:
  - req_ready returns high in the cycle after WRITE or ERR.
  - Next acceptance is at T+2 (full/err) or T+4 (partial).
- req_valid held high while req_ready=0 is simply not accepted. No request is dropped or duplicated.
- mem_rd and mem_wr are never high in the same cycle.

## Test plan

- DATA_W=32, byte store: addr 0x103, data 0x000000AB, mem_rdata 0x11223344.
  - Expect mem_rd T+1 with mem_addr 0x100.
  - Expect mem_wr and done T+3 with mem_wdata 0xAB223344.
- Half store: addr 0x202, data 0x0000BEEF, mem_rdata 0xCAFE1234.
  - Expect mem_wdata 0xBEEF1234 at mem_addr 0x200.
- Full store: addr 0x301, data 0xDEADBEEF.
  - Expect no mem_rd; mem_wr and done T+1; mem_addr 0x300; mem_wdata 0xDEADBEEF.
- Misaligned half: addr 0x201.
  - Expect err T+1; no mem_rd, mem_wr or done; req_ready high T+2.
  - A following byte store is then accepted at T+2.
- Reset mid-operation: reset asserted during WAIT of a byte store.
  - Expect all strobes 0 immediately and IDLE; no mem_wr after release.
  - The next store completes normally.
- DATA_W=64, size 11: addr 0x404, data 0x12345678, mem_rdata 0xFFFFFFFF_FFFFFFFF.
  - Expect mem_wdata 0x12345678_FFFFFFFF at mem_addr 0x400.

Source files
------------

// File: rtl/store_merge_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_merge_unit_if : request and data-memory bus of the store engine    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface store_merge_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );
endinterface
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_merge_unit : read-modify-write store engine merging sub-word lanes |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module store_merge_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  store_merge_unit_if.slave io_bus
);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam bit c_WIDE = (DATA_W == 64);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_size;
  logic [OFF_W-1:0]  r_off;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_full;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_base_mask;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_merged;
  logic [OFF_W+2:0]  w_shamt;

  assign w_accept = io_bus.req_valid && (r_state == S_IDLE);

  // Size 11 only means a 32-bit lane on a 64-bit word; otherwise it is full.
  assign w_full = (io_bus.req_size == 2'b00) ||
                  ((io_bus.req_size == 2'b11) && !c_WIDE);

  assign w_misaligned = ((io_bus.req_size == 2'b01) && io_bus.req_addr[0]) ||
                        ((io_bus.req_size == 2'b11) && c_WIDE &&
                         (io_bus.req_addr[1:0] != 2'b00));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)  w_next = S_ERR;
          else if (w_full)   w_next = S_WRITE;
          else               w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_base_mask = '0;
    case (r_size)
      2'b10:   w_base_mask = DATA_W'(8'hFF);
      2'b01:   w_base_mask = DATA_W'(16'hFFFF);
      default: w_base_mask = DATA_W'(32'hFFFF_FFFF);
    endcase
  end

  assign w_shamt     = {r_off, 3'b000};
  assign w_lane_mask = w_base_mask << w_shamt;
  assign w_merged    = (io_bus.mem_rdata & ~w_lane_mask) |
                       ((r_data & w_base_mask) << w_shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_size     <= 2'b00;
      r_off      <= '0;
      r_data     <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Strobes are decoded from the next state so they are registered outputs.
      r_mem_rd <= (w_next == S_READ);
      r_mem_wr <= (w_next == S_WRITE);
      r_done   <= (w_next == S_WRITE);
      r_err    <= (w_next == S_ERR);
      if (w_accept) begin
        r_size     <= io_bus.req_size;
        r_off      <= io_bus.req_addr[OFF_W-1:0];
        r_data     <= io_bus.req_data;
        r_mem_addr <= {io_bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (w_full) begin
          r_wdata <= io_bus.req_data;
        end
      end
      if (r_state == S_WAIT) begin
        r_wdata <= w_merged;
      end
    end
  end

  assign io_bus.req_ready = (r_state == S_IDLE);
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_rd    = r_mem_rd;
  assign io_bus.mem_wr    = r_mem_wr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_merge_unit : directed bench for 32- and 64-bit store merging    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_store_merge_unit;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  store_merge_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  store_merge_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  store_merge_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus32)
  );

  store_merge_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue32(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    chk("ready_before_req", {63'd0, bus32.req_ready}, 64'd1);
    bus32.req_valid = 1'b1;
    bus32.req_addr  = a;
    bus32.req_size  = s;
    bus32.req_data  = d;
    @(posedge clk);
    #1;
    bus32.req_valid = 1'b0;
  endtask

  initial begin
    int seen;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus32.req_valid = 1'b0; bus32.req_addr = '0; bus32.req_size = '0;
    bus32.req_data  = '0;   bus32.mem_rdata = '0;
    bus64.req_valid = 1'b0; bus64.req_addr = '0; bus64.req_size = '0;
    bus64.req_data  = '0;   bus64.mem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", {63'd0, bus32.req_ready}, 64'd1);
    chk("rst_rd",    {63'd0, bus32.mem_rd},    64'd0);
    chk("rst_wr",    {63'd0, bus32.mem_wr},    64'd0);
    chk("rst_done",  {63'd0, bus32.done},      64'd0);
    chk("rst_err",   {63'd0, bus32.err},       64'd0);
    chk("rst_addr",  {32'd0, bus32.mem_addr},  64'd0);
    chk("rst_wdata", {32'd0, bus32.mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // Byte store
    issue32(32'h103, 2'b10, 32'h0000_00AB);
    @(negedge clk);
    chk("byte_rd",    {63'd0, bus32.mem_rd},   64'd1);
    chk("byte_wr_t1", {63'd0, bus32.mem_wr},   64'd0);
    chk("byte_addr",  {32'd0, bus32.mem_addr}, 64'h100);
    chk("byte_busy",  {63'd0, bus32.req_ready}, 64'd0);
    bus32.mem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("byte_rd_t2", {63'd0, bus32.mem_rd}, 64'd0);
    chk("byte_wr_t2", {63'd0, bus32.mem_wr}, 64'd0);
    @(negedge clk);
    chk("byte_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("byte_done",  {63'd0, bus32.done},      64'd1);
    chk("byte_wdata", {32'd0, bus32.mem_wdata}, 64'hAB22_3344);
    chk("byte_addr3", {32'd0, bus32.mem_addr},  64'h100);
    @(negedge clk);
    chk("byte_wr_end", {63'd0, bus32.mem_wr},    64'd0);
    chk("byte_ready",  {63'd0, bus32.req_ready}, 64'd1);

    // Half store
    issue32(32'h202, 2'b01, 32'h0000_BEEF);
    @(negedge clk);
    chk("half_rd", {63'd0, bus32.mem_rd}, 64'd1);
    bus32.mem_rdata = 32'hCAFE_1234;
    @(negedge clk);
    @(negedge clk);
    chk("half_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("half_wdata", {32'd0, bus32.mem_wdata}, 64'hBEEF_1234);
    chk("half_addr",  {32'd0, bus32.mem_addr},  64'h200);

    // Full store, offset bits ignored
    issue32(32'h301, 2'b00, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("full_rd",    {63'd0, bus32.mem_rd},    64'd0);
    chk("full_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("full_done",  {63'd0, bus32.done},      64'd1);
    chk("full_addr",  {32'd0, bus32.mem_addr},  64'h300);
    chk("full_wdata", {32'd0, bus32.mem_wdata}, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("full_ready", {63'd0, bus32.req_ready}, 64'd1);

    // Size 11 on a 32-bit word behaves as full
    issue32(32'h013, 2'b11, 32'h0102_0304);
    @(negedge clk);
    chk("w32_rd",    {63'd0, bus32.mem_rd},    64'd0);
    chk("w32_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("w32_addr",  {32'd0, bus32.mem_addr},  64'h010);
    chk("w32_wdata", {32'd0, bus32.mem_wdata}, 64'h0102_0304);

    // Misaligned half, then a byte store held pending during ERR
    issue32(32'h201, 2'b01, 32'h0000_1111);
    @(negedge clk);
    chk("mis_err",  {63'd0, bus32.err},       64'd1);
    chk("mis_rd",   {63'd0, bus32.mem_rd},    64'd0);
    chk("mis_wr",   {63'd0, bus32.mem_wr},    64'd0);
    chk("mis_done", {63'd0, bus32.done},      64'd0);
    chk("mis_busy", {63'd0, bus32.req_ready}, 64'd0);
    bus32.req_valid = 1'b1;
    bus32.req_addr  = 32'h205;
    bus32.req_size  = 2'b10;
    bus32.req_data  = 32'h0000_005A;
    @(negedge clk);
    chk("mis_ready",   {63'd0, bus32.req_ready}, 64'd1);
    chk("mis_err_end", {63'd0, bus32.err},       64'd0);
    chk("mis_no_rd",   {63'd0, bus32.mem_rd},    64'd0);
    @(posedge clk);
    #1;
    bus32.req_valid = 1'b0;
    bus32.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("post_rd",   {63'd0, bus32.mem_rd},   64'd1);
    chk("post_addr", {32'd0, bus32.mem_addr}, 64'h204);
    @(negedge clk);
    @(negedge clk);
    chk("post_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("post_wdata", {32'd0, bus32.mem_wdata}, 64'hFFFF_5AFF);
    @(negedge clk);
    chk("post_single", {63'd0, bus32.mem_wr}, 64'd0);

    // Reset during WAIT abandons the store
    issue32(32'h001, 2'b10, 32'h0000_00CC);
    @(negedge clk);
    chk("rmid_rd", {63'd0, bus32.mem_rd}, 64'd1);
    bus32.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_rd0",    {63'd0, bus32.mem_rd},    64'd0);
    chk("rmid_wr0",    {63'd0, bus32.mem_wr},    64'd0);
    chk("rmid_done0",  {63'd0, bus32.done},      64'd0);
    chk("rmid_ready",  {63'd0, bus32.req_ready}, 64'd1);
    chk("rmid_wdata0", {32'd0, bus32.mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus32.mem_wr || bus32.done) seen++;
    end
    chk("rmid_no_wr", 64'(seen), 64'd0);
    issue32(32'h002, 2'b10, 32'h0000_0077);
    @(negedge clk);
    bus32.mem_rdata = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    chk("rnext_wr",    {63'd0, bus32.mem_wr},    64'd1);
    chk("rnext_wdata", {32'd0, bus32.mem_wdata}, 64'h1177_3344);

    // 64-bit word store in the upper half
    @(negedge clk);
    bus64.req_valid = 1'b1;
    bus64.req_addr  = 32'h404;
    bus64.req_size  = 2'b11;
    bus64.req_data  = 64'h0000_0000_1234_5678;
    @(posedge clk);
    #1;
    bus64.req_valid = 1'b0;
    @(negedge clk);
    chk("w64_rd",   {63'd0, bus64.mem_rd},   64'd1);
    chk("w64_addr", {32'd0, bus64.mem_addr}, 64'h400);
    bus64.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    chk("w64_wr",    {63'd0, bus64.mem_wr}, 64'd1);
    chk("w64_done",  {63'd0, bus64.done},   64'd1);
    chk("w64_wdata", bus64.mem_wdata,       64'h1234_5678_FFFF_FFFF);

    // 64-bit misaligned word
    @(negedge clk);
    bus64.req_valid = 1'b1;
    bus64.req_addr  = 32'h402;
    @(posedge clk);
    #1;
    bus64.req_valid = 1'b0;
    @(negedge clk);
    chk("w64_mis_err", {63'd0, bus64.err},    64'd1);
    chk("w64_mis_rd",  {63'd0, bus64.mem_rd}, 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
